icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped instruction cache that answers the fetch-address stream from the PC stage.
- Takes the fetch address each cycle, returns the instruction word one cycle later on a hit, and holds the front end with a combinational stall on a miss.
- On a miss, refills a 4-word line from the memory read port with a request/beat handshake.
- Sits between the PC stage and the memory bus arbiter. The fetch address is treated as physical; no translation is done here.

Parameters:
- INDEX_BITS, 6, log2 of number of lines (64 lines, 16 bytes each).
- TAG_BITS, 32-4-INDEX_BITS (derived, localparam), tag width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- fetch_addr  input  32  fetch address from PC stage; [1:0] ignored
- fetch_req  input  1  lookup requested this cycle
- flush  input  1  squash pending output; a refill already in flight still completes
- inv_all  input  1  invalidate every line
- miss_stall  output  1  combinational; front end must hold fetch_addr while high
- inst  output  32  instruction word
- inst_valid  output  1  inst is valid this cycle
- mem_rd_req  output  1  line read request
- mem_rd_addr  output  32  line-aligned read address ([3:0]=0)
- mem_rd_rdy  input  1  arbiter accepts request
- mem_rd_data  input  32  beat data
- mem_rd_valid  input  1  beat valid
- mem_rd_last  input  1  final beat (4th)

Behaviour:
- Address split:
  - word = fetch_addr[3:2]
  - index = fetch_addr[3+INDEX_BITS:4]
  - tag = fetch_addr[31:4+INDEX_BITS]
- Storage: valid bit, tag and 4 data words per line. Tag/data read combinationally from fetch_addr.
- Reset (asynchronous):
  - All valid bits 0, state IDLE.
  - inst=0, inst_valid=0, mem_rd_req=0, mem_rd_addr=0.
  - Beat counter 0, pending-invalidate flag 0.
- hit = fetch_req & state==IDLE & valid[index] & tag match.
- miss_stall = fetch_req & !hit. It is also high in every non-IDLE state regardless of address.
- Hit latency: inst and inst_valid are registered. Hit in cycle N gives inst_valid=1 in cycle N+1 with the selected word.
- inst_valid is 0 in N+1 if:
  - no hit occurred in cycle N, or
  - flush is high in cycle N.
- FSM:
  - IDLE: on fetch_req & !hit & !flush, latch line address = {fetch_addr[31:4],4'b0} and go to REQ.
  - REQ: mem_rd_req=1, mem_rd_addr=latched address, both held stable until mem_rd_rdy. On the rdy cycle, go to REFILL and clear the beat counter.
  - REFILL: each mem_rd_valid writes mem_rd_data into a line buffer at the beat counter position (word 0 first), then increments the counter (2-bit, wraps). On valid & last, go to FILL.
  - FILL: write the buffer into data array[index], tag, valid=1; return to IDLE.
  - The next cycle repeats the lookup from the held fetch_addr and hits. Miss-to-inst_valid latency = refill cycles + 2.
- mem_rd_last at a beat count other than 3: the line is still written. Words not received are undefined. This is a bus protocol violation and is not checked.
- flush during REQ/REFILL/FILL: the refill completes and the line is installed. Only output is squashed. After FILL, the IDLE lookup uses the then-current fetch_addr.
- flush and a hit in the same cycle: inst_valid=0 next cycle.
- inv_all in IDLE: all valid bits clear at the next edge. A hit in that same cycle still returns its data.
- inv_all in a non-IDLE state: sets the pending flag. The flag is applied in the cycle after FILL (cleared at the same time), invalidating the just-installed line too.
- fetch_req=0 in IDLE: no state change, miss_stall=0, inst_valid=0 next cycle.
- Reset mid-refill: state returns to IDLE immediately, mem_rd_req drops, and the partial line is discarded. The memory side must tolerate an abandoned transaction.

Test Plan:
- Cold miss:
  - Stimulus: reset, fetch_addr=0x1C000008, fetch_req=1; arbiter rdy after 2 cycles; beats 0xA0,0xA1,0xA2,0xA3 (last on 4th).
  - Required: miss_stall high throughout; mem_rd_addr=0x1C000000; the cycle after the FILL→IDLE lookup gives inst=0xA2, inst_valid=1.
- Back-to-back hits: fetch 0x1C000000 then 0x1C00000C on consecutive cycles → inst 0xA0 then 0xA3, each one cycle later, miss_stall low.
- Conflict eviction:
  - Stimulus: fetch 0x1C000400 (same index as 0x1C000000 when INDEX_BITS=6), refill with 0xB0..0xB3, then refetch 0x1C000000.
  - Required: second miss and refill occur; 0xB-line is returned for 0x1C000400.
- Flush mid-refill: assert flush for 1 cycle during REFILL → line is still installed; a later fetch of the same line hits with no mem_rd_req.
- Invalidate during refill: pulse inv_all in REQ → after FILL all lines are invalid, and the same address misses again (mem_rd_req reasserts).
- Async reset mid-refill: assert rst between beats 1 and 2 → mem_rd_req=0 and inst_valid=0 immediately; a refetch misses.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache, 4-word lines, one-cycle hit.
// Misses stall the front end and refill the line over the memory read port.
module icache_responder #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic        inv_all,
  output logic        miss_stall,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_rdy,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  input  logic        mem_rd_last
);

  localparam int TAG_BITS = 32 - 4 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REFILL,
    S_FILL
  } state_t;

  state_t r_state;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES][4];
  logic [31:0]         r_buf  [4];
  logic [1:0]          r_beat;
  logic                r_inv_pend;

  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic        r_mem_rd_req;
  logic [31:0] r_mem_rd_addr;

  logic [1:0]            w_word;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_idle;
  logic                  w_hit;
  logic [31:0]           w_hit_word;

  assign w_word     = fetch_addr[3:2];
  assign w_idx      = fetch_addr[3+INDEX_BITS:4];
  assign w_tag      = fetch_addr[31:4+INDEX_BITS];
  // The latched request address doubles as the fill target.
  assign w_fill_idx = r_mem_rd_addr[3+INDEX_BITS:4];
  assign w_fill_tag = r_mem_rd_addr[31:4+INDEX_BITS];

  assign w_idle     = (r_state == S_IDLE);
  assign w_hit      = fetch_req & w_idle & r_valid[w_idx]
                    & (r_tag[w_idx] == w_tag);
  assign w_hit_word = r_data[w_idx][w_word];

  assign miss_stall  = ~w_idle | (fetch_req & ~w_hit);
  assign inst        = r_inst;
  assign inst_valid  = r_inst_valid;
  assign mem_rd_req  = r_mem_rd_req;
  assign mem_rd_addr = r_mem_rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (r_state == S_FILL) begin
      r_valid[w_fill_idx] <= 1'b1;
    end else if (w_idle && (inv_all || r_inv_pend)) begin
      r_valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mem_rd_valid) begin
      r_buf[r_beat] <= mem_rd_data;
    end
    if (r_state == S_FILL) begin
      r_tag[w_fill_idx] <= w_fill_tag;
      for (int w = 0; w < 4; w++) begin
        r_data[w_fill_idx][w] <= r_buf[w];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_beat        <= 2'd0;
      r_inv_pend    <= 1'b0;
      r_inst        <= 32'd0;
      r_inst_valid  <= 1'b0;
      r_mem_rd_req  <= 1'b0;
      r_mem_rd_addr <= 32'd0;
    end else begin
      r_inst_valid <= w_hit & ~flush;
      if (w_hit) begin
        r_inst <= w_hit_word;
      end
      unique case (r_state)
        S_IDLE: begin
          r_inv_pend <= 1'b0;
          if (fetch_req && !w_hit && !flush) begin
            r_mem_rd_addr <= {fetch_addr[31:4], 4'b0};
            r_mem_rd_req  <= 1'b1;
            r_state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (inv_all) r_inv_pend <= 1'b1;
          if (mem_rd_rdy) begin
            r_mem_rd_req <= 1'b0;
            r_beat       <= 2'd0;
            r_state      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (inv_all) r_inv_pend <= 1'b1;
          if (mem_rd_valid) begin
            r_beat <= r_beat + 2'd1;
            if (mem_rd_last) r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (inv_all) r_inv_pend <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: misses, hits, eviction,
// flush, invalidate and reset during refill.
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        flush;
  logic        inv_all;
  logic        miss_stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_rdy;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_rd_last;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  icache_responder dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_addr   (fetch_addr),
    .fetch_req    (fetch_req),
    .flush        (flush),
    .inv_all      (inv_all),
    .miss_stall   (miss_stall),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_rdy   (mem_rd_rdy),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_last  (mem_rd_last)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [31:0] addr, input logic [31:0] d0,
                       input int dly, input int flush_beat);
    int n = 0;
    while (!mem_rd_req && n < 20) begin
      cyc();
      n++;
    end
    check("req_seen", {31'd0, mem_rd_req}, 32'd1);
    check("rd_addr", mem_rd_addr, addr);
    for (int i = 0; i < dly; i++) begin
      cyc();
      check("req_hold", {30'd0, mem_rd_req, miss_stall}, 32'd3);
      check("addr_hold", mem_rd_addr, addr);
    end
    mem_rd_rdy = 1'b1;
    cyc();
    mem_rd_rdy = 1'b0;
    check("req_drop", {31'd0, mem_rd_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = d0 + i;
      mem_rd_last  = (i == 3);
      flush        = (i == flush_beat);
      cyc();
      check("refill_stall", {31'd0, miss_stall}, 32'd1);
    end
    mem_rd_valid = 1'b0;
    mem_rd_last  = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic finish_fill(input logic [31:0] exp_inst);
    cyc();
    check("lookup_hit", {31'd0, miss_stall}, 32'd0);
    check("lookup_nv", {31'd0, inst_valid}, 32'd0);
    cyc();
    check("fill_valid", {31'd0, inst_valid}, 32'd1);
    check("fill_inst", inst, exp_inst);
  endtask

  initial begin
    rst          = 1'b1;
    fetch_addr   = 32'd0;
    fetch_req    = 1'b0;
    flush        = 1'b0;
    inv_all      = 1'b0;
    mem_rd_rdy   = 1'b0;
    mem_rd_data  = 32'd0;
    mem_rd_valid = 1'b0;
    mem_rd_last  = 1'b0;
    #12;
    check("rst_inst", inst, 32'd0);
    check("rst_iv", {31'd0, inst_valid}, 32'd0);
    check("rst_req", {31'd0, mem_rd_req}, 32'd0);
    check("rst_addr", mem_rd_addr, 32'd0);
    check("rst_stall", {31'd0, miss_stall}, 32'd0);
    rst = 1'b0;
    cyc();

    // cold miss
    fetch_addr = 32'h1C000008;
    fetch_req  = 1'b1;
    #1;
    check("cold_stall", {31'd0, miss_stall}, 32'd1);
    cyc();
    serve(32'h1C000000, 32'hA0, 2, -1);
    finish_fill(32'hA2);

    // back-to-back hits
    fetch_addr = 32'h1C000000;
    #1;
    check("hit0_stall", {31'd0, miss_stall}, 32'd0);
    cyc();
    check("hit0_iv", {31'd0, inst_valid}, 32'd1);
    check("hit0_inst", inst, 32'hA0);
    fetch_addr = 32'h1C00000C;
    #1;
    check("hit1_stall", {31'd0, miss_stall}, 32'd0);
    cyc();
    check("hit1_iv", {31'd0, inst_valid}, 32'd1);
    check("hit1_inst", inst, 32'hA3);
    check("hit1_req", {31'd0, mem_rd_req}, 32'd0);

    // conflict eviction on index 0
    fetch_addr = 32'h1C000400;
    #1;
    check("conf_stall", {31'd0, miss_stall}, 32'd1);
    cyc();
    serve(32'h1C000400, 32'hB0, 0, -1);
    finish_fill(32'hB0);
    fetch_addr = 32'h1C000004;
    #1;
    check("evict_stall", {31'd0, miss_stall}, 32'd1);
    cyc();
    serve(32'h1C000000, 32'hA0, 1, -1);
    finish_fill(32'hA1);

    // idle with no request
    fetch_req = 1'b0;
    #1;
    check("noreq_stall", {31'd0, miss_stall}, 32'd0);
    cyc();
    check("noreq_iv", {31'd0, inst_valid}, 32'd0);

    // flush mid-refill still installs the line
    fetch_addr = 32'h00002010;
    fetch_req  = 1'b1;
    cyc();
    serve(32'h00002010, 32'hC0, 0, 1);
    fetch_req = 1'b0;
    cyc();
    check("fl_post_iv", {31'd0, inst_valid}, 32'd0);
    fetch_addr = 32'h00002014;
    fetch_req  = 1'b1;
    #1;
    check("fl_hit_stall", {31'd0, miss_stall}, 32'd0);
    cyc();
    check("fl_hit_req", {31'd0, mem_rd_req}, 32'd0);
    check("fl_hit_iv", {31'd0, inst_valid}, 32'd1);
    check("fl_hit_inst", inst, 32'hC1);
    fetch_addr = 32'h00002018;
    flush      = 1'b1;
    cyc();
    flush = 1'b0;
    check("fl_sq_iv", {31'd0, inst_valid}, 32'd0);

    // invalidate pulse while in REQ
    fetch_addr = 32'h00003028;
    #1;
    check("inv_stall", {31'd0, miss_stall}, 32'd1);
    cyc();
    inv_all = 1'b1;
    cyc();
    inv_all = 1'b0;
    serve(32'h00003020, 32'hD0, 0, -1);
    finish_fill(32'hD2);
    check("inv_remiss", {31'd0, miss_stall}, 32'd1);
    serve(32'h00003020, 32'hE0, 0, -1);
    finish_fill(32'hE2);
    fetch_addr = 32'h00002014;
    #1;
    check("inv_other", {31'd0, miss_stall}, 32'd1);
    fetch_req = 1'b0;
    #1;
    cyc();
    check("inv_noreq", {31'd0, mem_rd_req}, 32'd0);

    // async reset between beats 1 and 2
    fetch_addr = 32'h00004034;
    fetch_req  = 1'b1;
    cyc();
    mem_rd_rdy = 1'b1;
    cyc();
    mem_rd_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'hF0 + i;
      cyc();
    end
    mem_rd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_req", {31'd0, mem_rd_req}, 32'd0);
    check("ar_iv", {31'd0, inst_valid}, 32'd0);
    check("ar_stall", {31'd0, miss_stall}, 32'd1);
    #2 rst = 1'b0;
    cyc();
    check("ar_refetch", {31'd0, mem_rd_req}, 32'd1);
    check("ar_addr", mem_rd_addr, 32'h00004030);
    #2 rst = 1'b1;
    #1;
    check("ar_req_drop", {31'd0, mem_rd_req}, 32'd0);
    check("ar_addr_clr", mem_rd_addr, 32'd0);
    #2 rst = 1'b0;
    cyc();
    serve(32'h00004030, 32'hF0, 0, -1);
    finish_fill(32'hF1);
    #2 rst = 1'b1;
    #1;
    check("ar_iv_clr", {31'd0, inst_valid}, 32'd0);
    check("ar_inst_clr", inst, 32'd0);
    #2 rst = 1'b0;
    fetch_addr = 32'h1C000000;
    #1;
    check("ar_cold", {31'd0, miss_stall}, 32'd1);
    fetch_req = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
